// File: rtl/spi_multidev_ctrl.sv
// ZXUNO-mapped SPI master for up to 8 devices sharing sclk/mosi, with per-device chip select and CPOL/CPHA modes.
// Define SPI_DIVIDER_EN to make the sclk divider register (REG_DIV) writable; otherwise sclk = clk/2.
module spi_multidev_ctrl #(
  parameter int          NDEV     = 4,
  parameter logic [7:0]  REG_CS   = 8'h02,
  parameter logic [7:0]  REG_DATA = 8'h03,
  parameter logic [7:0]  REG_CTRL = 8'h04,
  parameter logic [7:0]  REG_DIV  = 8'h05
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      addr,
  input  logic            ior,
  input  logic            iow,
  input  logic [7:0]      din,
  output logic [7:0]      dout,
  output logic            oe,
  output logic            wait_n,
  output logic [NDEV-1:0] spi_cs_n,
  output logic            sclk,
  output logic            mosi,
  input  logic [NDEV-1:0] miso_in,
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] NDEV_W = 4'(NDEV);

  state_t     state;
  logic       ior_q, iow_q;
  logic       cs_valid;
  logic [2:0] cs_idx;
  logic       cpol, cpha;
  logic [7:0] div_val;
  logic [7:0] div_cnt;
  logic [3:0] hp;
  logic [7:0] tx_sr, rx_sr, rx_reg;

  logic       rd_pulse, wr_pulse, busy, cs_ok, hp_end, start_go, miso_bit;
  logic [3:0] hp_nx;
  logic [7:0] start_data, miso_pad;

`ifdef SPI_DIVIDER_EN
  logic [7:0] div_q;
  assign div_val = div_q;
`else
  assign div_val = 8'h00;
`endif

  assign rd_pulse  = ior & ~ior_q;
  assign wr_pulse  = iow & ~iow_q;
  assign busy      = (state != IDLE);
  assign cs_ok     = !din[7] && ({1'b0, din[2:0]} < NDEV_W);
  assign hp_end    = (div_cnt == div_val);
  assign hp_nx     = hp + 4'd1;
  assign dbg_state = state;

  // A DATA read only starts a dummy transfer when no write is being decoded in the same cycle.
  always_comb begin
    start_go   = (state == IDLE) && (addr == REG_DATA) && (wr_pulse || rd_pulse);
    start_data = wr_pulse ? din : 8'hFF;
  end

  always_comb begin
    miso_pad             = 8'hFF;
    miso_pad[NDEV-1:0]   = miso_in;
    miso_bit             = cs_valid ? miso_pad[cs_idx] : 1'b1;
  end

  always_comb begin
    dout = 8'h00;
    oe   = 1'b0;
    if (ior) begin
      if (addr == REG_CS) begin
        oe   = 1'b1;
        dout = {busy, 4'b0000, cs_idx};
      end else if (addr == REG_DATA) begin
        oe   = 1'b1;
        dout = rx_reg;
      end else if (addr == REG_CTRL) begin
        oe   = 1'b1;
        dout = {6'b000000, cpol, cpha};
      end
`ifdef SPI_DIVIDER_EN
      else if (addr == REG_DIV) begin
        oe   = 1'b1;
        dout = div_q;
      end
`endif
    end
  end

  // Half-period k drives sclk = CPOL^CPHA^k[0]; entering an odd k samples miso, entering an even k shifts mosi.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ior_q    <= 1'b0;
      iow_q    <= 1'b0;
      cs_valid <= 1'b0;
      cs_idx   <= 3'b111;
      spi_cs_n <= '1;
      cpol     <= 1'b0;
      cpha     <= 1'b0;
`ifdef SPI_DIVIDER_EN
      div_q    <= 8'h00;
`endif
      div_cnt  <= 8'h00;
      hp       <= 4'd0;
      tx_sr    <= 8'h00;
      rx_sr    <= 8'h00;
      rx_reg   <= 8'hFF;
      sclk     <= 1'b0;
      mosi     <= 1'b1;
      wait_n   <= 1'b1;
    end else begin
      ior_q <= ior;
      iow_q <= iow;
      case (state)
        IDLE: begin
          sclk <= cpol;
          mosi <= 1'b1;
          if (wr_pulse && addr == REG_CS) begin
            cs_valid <= cs_ok;
            cs_idx   <= cs_ok ? din[2:0] : 3'b111;
            for (int i = 0; i < NDEV; i++)
              spi_cs_n[i] <= !(cs_ok && din[2:0] == 3'(i));
          end else if (wr_pulse && addr == REG_CTRL) begin
            cpha <= din[0];
            cpol <= din[1];
            sclk <= din[1];
          end
`ifdef SPI_DIVIDER_EN
          else if (wr_pulse && addr == REG_DIV) begin
            div_q <= din;
          end
`endif
          if (start_go) begin
            state   <= SHIFT;
            wait_n  <= 1'b0;
            tx_sr   <= start_data;
            mosi    <= start_data[7];
            div_cnt <= 8'h00;
            hp      <= 4'd0;
            sclk    <= cpol ^ cpha;
          end
        end
        SHIFT: begin
          if (hp_end) begin
            div_cnt <= 8'h00;
            if (hp == 4'd15) begin
              state <= DONE;
              sclk  <= cpol;
              mosi  <= 1'b1;
            end else begin
              hp   <= hp_nx;
              sclk <= cpol ^ cpha ^ hp_nx[0];
              if (hp_nx[0]) begin
                rx_sr <= {rx_sr[6:0], miso_bit};
              end else begin
                mosi  <= tx_sr[6];
                tx_sr <= {tx_sr[6:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        DONE: begin
          rx_reg <= rx_sr;
          wait_n <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
